// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin sharing of one register-file port between SPI strobes and an internal master
// Optional feature: ACCESS_TIMEOUT_EN aborts a stalled register-file access after TIMEOUT_CYCLES.
module reg_bus_arbiter #(
  parameter int                 ADDR_W         = 8,
  parameter int                 DATA_W         = 32,
  parameter int                 TIMEOUT_CYCLES = 256,
  parameter logic [DATA_W-1:0]  ERR_DATA       = 32'hDEADDEAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  input  logic              spi_write,
  input  logic              spi_read,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              spi_rvalid,
  output logic              spi_overrun,
  input  logic              int_req,
  input  logic              int_we,
  input  logic [ADDR_W-1:0] int_addr,
  input  logic [DATA_W-1:0] int_wdata,
  output logic              int_gnt,
  output logic              int_done,
  output logic [DATA_W-1:0] int_rdata,
  output logic              rf_req,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  input  logic              rf_ack,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
  localparam logic SRC_SPI = 1'b0;
  localparam logic SRC_INT = 1'b1;

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  logic              pend_we_q, pend_we_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;
  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              rf_req_q, rf_req_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              gnt_q, gnt_d;
  logic              ovr_q, ovr_d;
  logic              spi_strobe, spi_issue, int_issue;

`ifdef ACCESS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  always_comb begin
    spi_strobe = spi_write | spi_read;
    spi_issue  = 1'b0;
    int_issue  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (pend_q && int_req) begin
        if (last_q == SRC_INT) spi_issue = 1'b1;
        else                   int_issue = 1'b1;
      end else if (pend_q) begin
        spi_issue = 1'b1;
      end else if (int_req) begin
        int_issue = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_we_d    = pend_we_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    last_d       = last_q;
    owner_d      = owner_q;
    rf_req_d     = rf_req_q;
    rf_we_d      = rf_we_q;
    rf_addr_d    = rf_addr_q;
    rf_wdata_d   = rf_wdata_q;
    rdata_d      = rdata_q;
    gnt_d        = 1'b0;
    ovr_d        = 1'b0;
`ifdef ACCESS_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = 1'b0;
`endif

    // The buffer slot frees in the same cycle it is issued, so a strobe then is kept.
    if (spi_issue) pend_d = 1'b0;
    if (spi_strobe) begin
      if (!pend_q || spi_issue) begin
        pend_d       = 1'b1;
        pend_we_d    = spi_write;
        pend_addr_d  = spi_addr;
        pend_wdata_d = spi_wdata;
      end else begin
        ovr_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (spi_issue) begin
          state_d    = ST_ACCESS;
          rf_req_d   = 1'b1;
          rf_we_d    = pend_we_q;
          rf_addr_d  = pend_addr_q;
          rf_wdata_d = pend_wdata_q;
          owner_d    = SRC_SPI;
          last_d     = SRC_SPI;
        end else if (int_issue) begin
          state_d    = ST_ACCESS;
          rf_req_d   = 1'b1;
          rf_we_d    = int_we;
          rf_addr_d  = int_addr;
          rf_wdata_d = int_wdata;
          owner_d    = SRC_INT;
          last_d     = SRC_INT;
          gnt_d      = 1'b1;
        end
`ifdef ACCESS_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      ST_ACCESS: begin
        if (rf_ack) begin
          rf_req_d = 1'b0;
          rdata_d  = rf_rdata;
          state_d  = ST_RESP;
`ifdef ACCESS_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rf_req_d = 1'b0;
          rdata_d  = ERR_DATA;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        rf_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      last_q       <= SRC_INT;
      owner_q      <= SRC_SPI;
      rf_req_q     <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_wdata_q   <= '0;
      rdata_q      <= '0;
      gnt_q        <= 1'b0;
      ovr_q        <= 1'b0;
`ifdef ACCESS_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      rf_req_q     <= rf_req_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_wdata_q   <= rf_wdata_d;
      rdata_q      <= rdata_d;
      gnt_q        <= gnt_d;
      ovr_q        <= ovr_d;
`ifdef ACCESS_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign rf_req      = rf_req_q;
  assign rf_we       = rf_we_q;
  assign rf_addr     = rf_addr_q;
  assign rf_wdata    = rf_wdata_q;
  assign int_gnt     = gnt_q;
  assign spi_overrun = ovr_q;
  assign spi_rdata   = rdata_q;
  assign int_rdata   = rdata_q;
  assign spi_rvalid  = (state_q == ST_RESP) && (owner_q == SRC_SPI) && !rf_we_q;
  assign int_done    = (state_q == ST_RESP) && (owner_q == SRC_INT);
  assign busy        = (state_q != ST_IDLE) || pend_q;
`ifdef ACCESS_TIMEOUT_EN
  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
